// File: rtl/mcpu5_prog_feeder_if.sv
// Program-load port of the MCPU5 program feeder: one 6-bit instruction
// word per beat, transferred when load_valid and load_ready are both high.
interface mcpu5_prog_feeder_if;
    logic       load_valid;
    logic [5:0] load_data;
    logic       load_last;
    logic       load_ready;

    modport master (
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/mcpu5_prog_feeder.sv
// MCPU5 program feeder: small program RAM loaded over a valid/ready port,
// served to the core as inst_out = mem[pc_in] while running. Holds the
// core in reset (cpu_rst) whenever the program is absent or being loaded.
// Optional macro HALT_DETECT_EN adds a sticky branch-to-self detector
// driving halted; without it halted is tied low.
module mcpu5_prog_feeder #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter logic [5:0]  NOP   = 6'b111100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  run_start,
    mcpu5_prog_feeder_if.slave    load,
    input  logic [7:0]            pc_in,
    output logic [5:0]            inst_out,
    output logic                  cpu_rst,
    output logic                  halted
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic          load_ready;
    logic [5:0]    mem [DEPTH];
    logic          beat;

    assign load.load_ready = load_ready;
    assign beat            = load.load_valid & load_ready;

    // Sequencer: state, write pointer and registered handshake / core reset.
    // cpu_rst rises on the same edge that enters LOAD but only falls one
    // edge after RUN is entered, so the core never sees a partial program.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            load_ready <= 1'b0;
            cpu_rst    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    cpu_rst <= 1'b1;
                    if (load_start) begin
                        state      <= ST_LOAD;
                        wr_ptr     <= '0;
                        load_ready <= 1'b1;
                    end else if (run_start) begin
                        state <= ST_RUN;
                    end
                end
                ST_LOAD: begin
                    cpu_rst <= 1'b1;
                    if (load_start) begin
                        wr_ptr <= '0;
                    end else if (beat) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (load.load_last || wr_ptr == LAST_ADDR) begin
                            state      <= ST_RUN;
                            load_ready <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (load_start) begin
                        state      <= ST_LOAD;
                        wr_ptr     <= '0;
                        load_ready <= 1'b1;
                        cpu_rst    <= 1'b1;
                    end else begin
                        cpu_rst <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    load_ready <= 1'b0;
                    cpu_rst    <= 1'b1;
                end
            endcase
        end
    end

    // Program RAM: filled with NOP on reset, written one word per accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP;
            end
        end else if (beat) begin
            mem[wr_ptr] <= load.load_data;
        end
    end

    // Zero-latency instruction read; out-of-range PCs see NOP instead of aliasing.
    always_comb begin
        inst_out = NOP;
        if (state == ST_RUN && {1'b0, pc_in} < 9'(DEPTH)) begin
            inst_out = mem[pc_in[AW-1:0]];
        end
    end

`ifdef HALT_DETECT_EN
    logic [7:0] last_pc;
    logic       last_pc_vld;
    logic       match_seen;

    // Halt detector: BCC +0 at an unchanged PC on two consecutive clocks sets
    // a sticky flag; any load_start (entry into LOAD) clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pc     <= '0;
            last_pc_vld <= 1'b0;
            match_seen  <= 1'b0;
            halted      <= 1'b0;
        end else if (load_start) begin
            last_pc_vld <= 1'b0;
            match_seen  <= 1'b0;
            halted      <= 1'b0;
        end else if (state == ST_RUN) begin
            last_pc     <= pc_in;
            last_pc_vld <= 1'b1;
            if (last_pc_vld && pc_in == last_pc && inst_out == 6'b000000) begin
                match_seen <= 1'b1;
                if (match_seen) begin
                    halted <= 1'b1;
                end
            end else begin
                match_seen <= 1'b0;
            end
        end else begin
            last_pc_vld <= 1'b0;
            match_seen  <= 1'b0;
        end
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mcpu5_prog_feeder.sv
module tb_mcpu5_prog_feeder;

    localparam logic [5:0] NOP = 6'b111100;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic       run_start;
    logic [7:0] pc_in;
    logic [5:0] inst_out;
    logic       cpu_rst;
    logic       halted;

    int checks = 0;
    int errors = 0;

    logic [5:0] model_mem [32];
    logic [5:0] exp_q [$];
    logic [5:0] got_exp;

    mcpu5_prog_feeder_if ld_if ();

    mcpu5_prog_feeder #(
        .DEPTH (32),
        .AW    (5),
        .NOP   (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .run_start  (run_start),
        .load       (ld_if),
        .pc_in      (pc_in),
        .inst_out   (inst_out),
        .cpu_rst    (cpu_rst),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_mem[i] = NOP;
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
        checks++; if (ld_if.load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready: got %b expected 0", ld_if.load_ready); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (inst_out !== NOP) begin errors++; $display("FAIL reset_inst_out: got %b expected %b", inst_out, NOP); end
        rst = 1'b0;
        @(negedge clk);
        pulse_load_start();
        checks++; if (ld_if.load_ready !== 1'b1) begin errors++; $display("FAIL midload_ready: got %b expected 1", ld_if.load_ready); end
        ld_if.load_valid = 1'b1; ld_if.load_data = 6'b010101; ld_if.load_last = 1'b0;
        @(negedge clk);
        ld_if.load_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_clear();
        checks++; if (ld_if.load_ready !== 1'b0) begin errors++; $display("FAIL async_rst_load_ready: got %b expected 0", ld_if.load_ready); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL async_rst_cpu_rst: got %b expected 1", cpu_rst); end
        checks++; if (inst_out !== NOP) begin errors++; $display("FAIL async_rst_inst_out: got %b expected %b", inst_out, NOP); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load3();
        logic [5:0] words [3];
        words[0] = 6'b010001; words[1] = 6'b100000; words[2] = 6'b000000;
        pulse_load_start();
        for (int i = 0; i < 3; i++) begin
            ld_if.load_valid = 1'b1;
            ld_if.load_data  = words[i];
            ld_if.load_last  = (i == 2);
            model_mem[i] = words[i];
            @(negedge clk);
        end
        ld_if.load_valid = 1'b0; ld_if.load_last = 1'b0;
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL load3_run_entry_cpu_rst: got %b expected 1", cpu_rst); end
        checks++; if (ld_if.load_ready !== 1'b0) begin errors++; $display("FAIL load3_ready_after_last: got %b expected 0", ld_if.load_ready); end
        @(negedge clk);
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL load3_cpu_rst_low: got %b expected 0", cpu_rst); end
        for (int a = 0; a < 4; a++) begin
            pc_in = 8'(a);
            exp_q.push_back(model_mem[a]);
            #1;
            got_exp = exp_q.pop_front();
            checks++; if (inst_out !== got_exp) begin errors++; $display("FAIL load3_read pc=%0d: got %b expected %b", a, inst_out, got_exp); end
        end
        pc_in = 8'd1;
        exp_q.push_back(6'b100000);
        #1;
        got_exp = exp_q.pop_front();
        checks++; if (inst_out !== got_exp) begin errors++; $display("FAIL load3_pc1: got %b expected %b", inst_out, got_exp); end
        @(negedge clk);
    endtask

    task automatic test_full_load();
        int addrs [5] = '{0, 1, 5, 17, 31};
        pulse_load_start();
        for (int i = 0; i < 32; i++) begin
            checks++; if (ld_if.load_ready !== 1'b1) begin errors++; $display("FAIL full_ready beat=%0d: got %b expected 1", i, ld_if.load_ready); end
            ld_if.load_valid = 1'b1;
            ld_if.load_data  = 6'((i * 5 + 7) % 64);
            ld_if.load_last  = 1'b0;
            model_mem[i] = 6'((i * 5 + 7) % 64);
            @(negedge clk);
        end
        ld_if.load_data = 6'h15;
        checks++; if (ld_if.load_ready !== 1'b0) begin errors++; $display("FAIL full_33rd_ready: got %b expected 0", ld_if.load_ready); end
        @(negedge clk);
        ld_if.load_valid = 1'b0;
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL full_cpu_rst: got %b expected 0", cpu_rst); end
        for (int k = 0; k < 5; k++) begin
            pc_in = 8'(addrs[k]);
            exp_q.push_back(model_mem[addrs[k]]);
            #1;
            got_exp = exp_q.pop_front();
            checks++; if (inst_out !== got_exp) begin errors++; $display("FAIL full_read pc=%0d: got %b expected %b", addrs[k], inst_out, got_exp); end
        end
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        int pcs [4] = '{40, 32, 255, 31};
        for (int k = 0; k < 4; k++) begin
            pc_in = 8'(pcs[k]);
            exp_q.push_back(pcs[k] < 32 ? model_mem[pcs[k]] : NOP);
            #1;
            got_exp = exp_q.pop_front();
            checks++; if (inst_out !== got_exp) begin errors++; $display("FAIL range_read pc=%0d: got %b expected %b", pcs[k], inst_out, got_exp); end
        end
        @(negedge clk);
    endtask

    task automatic test_reload();
        int addrs [3] = '{0, 1, 5};
        pulse_load_start();
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reload_cpu_rst: got %b expected 1", cpu_rst); end
        checks++; if (ld_if.load_ready !== 1'b1) begin errors++; $display("FAIL reload_ready: got %b expected 1", ld_if.load_ready); end
        for (int i = 0; i < 2; i++) begin
            ld_if.load_valid = 1'b1;
            ld_if.load_data  = (i == 0) ? 6'h0A : 6'h33;
            ld_if.load_last  = (i == 1);
            model_mem[i] = (i == 0) ? 6'h0A : 6'h33;
            @(negedge clk);
        end
        ld_if.load_valid = 1'b0; ld_if.load_last = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            pc_in = 8'(addrs[k]);
            exp_q.push_back(model_mem[addrs[k]]);
            #1;
            got_exp = exp_q.pop_front();
            checks++; if (inst_out !== got_exp) begin errors++; $display("FAIL reload_read pc=%0d: got %b expected %b", addrs[k], inst_out, got_exp); end
        end
        @(negedge clk);
    endtask

    task automatic test_halt();
        logic [5:0] words [4];
        logic       exp_halt;
`ifdef HALT_DETECT_EN
        exp_halt = 1'b1;
`else
        exp_halt = 1'b0;
`endif
        words[0] = 6'b010001; words[1] = 6'b100000; words[2] = 6'b000001; words[3] = 6'b000000;
        pulse_load_start();
        for (int i = 0; i < 4; i++) begin
            ld_if.load_valid = 1'b1;
            ld_if.load_data  = words[i];
            ld_if.load_last  = (i == 3);
            model_mem[i] = words[i];
            @(negedge clk);
        end
        ld_if.load_valid = 1'b0; ld_if.load_last = 1'b0;
        pc_in = 8'd0;
        @(negedge clk);
        pc_in = 8'd3;
        exp_q.push_back(model_mem[3]);
        #1;
        got_exp = exp_q.pop_front();
        checks++; if (inst_out !== got_exp) begin errors++; $display("FAIL halt_inst pc=3: got %b expected %b", inst_out, got_exp); end
        repeat (2) @(negedge clk);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b expected 0", halted); end
        @(negedge clk);
        checks++; if (halted !== exp_halt) begin errors++; $display("FAIL halt_set: got %b expected %b", halted, exp_halt); end
        pulse_load_start();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear_on_load: got %b expected 0", halted); end
    endtask

    task automatic test_idle_and_run_start();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        pc_in = 8'd0;
        #1;
        checks++; if (inst_out !== NOP) begin errors++; $display("FAIL idle_inst_out: got %b expected %b", inst_out, NOP); end
        @(negedge clk);
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL run_start_entry_cpu_rst: got %b expected 1", cpu_rst); end
        @(negedge clk);
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL run_start_cpu_rst: got %b expected 0", cpu_rst); end
        checks++; if (ld_if.load_ready !== 1'b0) begin errors++; $display("FAIL run_start_ready: got %b expected 0", ld_if.load_ready); end
    endtask

    task automatic test_both_starts();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load_start = 1'b1;
        run_start  = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        run_start  = 1'b0;
        checks++; if (ld_if.load_ready !== 1'b1) begin errors++; $display("FAIL both_starts_ready: got %b expected 1", ld_if.load_ready); end
        @(negedge clk);
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL both_starts_cpu_rst: got %b expected 1", cpu_rst); end
        checks++; if (ld_if.load_ready !== 1'b1) begin errors++; $display("FAIL both_starts_ready_hold: got %b expected 1", ld_if.load_ready); end
    endtask

    initial begin
        rst = 1'b1;
        load_start = 1'b0;
        run_start  = 1'b0;
        pc_in      = 8'd0;
        ld_if.load_valid = 1'b0;
        ld_if.load_data  = 6'd0;
        ld_if.load_last  = 1'b0;
        model_clear();
        test_reset();
        test_load3();
        test_full_load();
        test_out_of_range();
        test_reload();
        test_halt();
        test_idle_and_run_start();
        test_both_starts();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
